// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states and default width.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out bout.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit slice per cycle, LSB first, result after WIDTH cycles.
// Handshake: start is taken only in IDLE; done pulses for one cycle when diff/borrow carry a new result.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, next_state;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             bin_q;
    logic [CW-1:0]    cnt;
    logic             slice_d, slice_bout;
    logic             last_slice;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bin_q),
        .d    (slice_d),
        .bout (slice_bout)
    );

    assign last_slice = (state == RUN) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_slice) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The final slice lands in res_sr on the same edge that enters DONE, so the
    // outputs take the freshly assembled word rather than the stale register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            bin_q  <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        bin_q <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {slice_d, res_sr[WIDTH-1:1]};
                    bin_q  <= slice_bout;
                    cnt    <= cnt + CW'(1);
                    if (last_slice) begin
                        diff   <= {slice_d, res_sr[WIDTH-1:1]};
                        borrow <= slice_bout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule
